// File: rtl/crash_detect.sv
`default_nettype none
// ============================================================================
// Module      : crash_detect
// Description : Wall, paddle and miss detection for the ball/paddle game, with
//               a PLAY/MISS/OVER life FSM. Define CRASH_SCORE_EN to enable
//               the paddle-hit score counter (oScore reads 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module crash_detect #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_Y    = 440,
    parameter int PADDLE_W    = 64,
    parameter int HOLD_CYCLES = 1000,
    parameter int COOLDOWN    = 16,
    parameter int LIVES_INIT  = 3
) (
    input  logic       iVGA_CLK,
    input  logic       iRST,
    input  logic [9:0] iBall_x,
    input  logic [9:0] iBall_y,
    input  logic [9:0] iPaddle_x,
    output logic [3:0] oCrash,
    output logic       oServe,
    output logic [7:0] oScore,
    output logic [1:0] oLives,
    output logic       oGame_over
);

    localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int c_COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [c_COOL_W-1:0] c_COOL_LOAD = c_COOL_W'(COOLDOWN);

    typedef enum logic [1:0] {
        S_PLAY = 2'd0,
        S_MISS = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          crash_q;
    logic                serve_q;
    logic [1:0]          lives_q;
    logic                over_q;
    logic [c_COOL_W-1:0] cool_q;
    logic [c_HOLD_W-1:0] hold_q;

    logic [10:0] w_ball_r;
    logic [10:0] w_ball_b;
    logic [10:0] w_pad_r;
    logic        w_left;
    logic        w_right;
    logic        w_up;
    logic        w_hit;
    logic        w_miss;
    logic        w_hit_new;

    // Edge sums are one bit wider than the coordinates so they never wrap.
    assign w_ball_r  = {1'b0, iBall_x} + 11'(BALL_SIZE);
    assign w_ball_b  = {1'b0, iBall_y} + 11'(BALL_SIZE);
    assign w_pad_r   = {1'b0, iPaddle_x} + 11'(PADDLE_W);

    assign w_left    = (iBall_x == 10'd0);
    assign w_right   = (w_ball_r >= 11'(SCREEN_W));
    assign w_up      = (iBall_y == 10'd0);
    assign w_hit     = (w_ball_b == 11'(PADDLE_Y)) &&
                       (w_ball_r > {1'b0, iPaddle_x}) &&
                       ({1'b0, iBall_x} < w_pad_r);
    assign w_miss    = (w_ball_b >= 11'(SCREEN_H)) && !w_hit;
    assign w_hit_new = (state_q == S_PLAY) && w_hit && (cool_q == '0);

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            state_q <= S_PLAY;
            crash_q <= 4'd0;
            serve_q <= 1'b0;
            lives_q <= 2'(LIVES_INIT);
            over_q  <= 1'b0;
            cool_q  <= '0;
            hold_q  <= '0;
        end else begin
            serve_q <= 1'b0;
            crash_q <= 4'd0;

            if (w_hit_new) begin
                cool_q <= c_COOL_LOAD;
            end else if (cool_q != '0) begin
                cool_q <= cool_q - c_COOL_W'(1);
            end

            case (state_q)
                S_PLAY: begin
                    // A miss blanks oCrash so the MISS dwell starts clean.
                    if (w_miss) begin
                        state_q <= S_MISS;
                        hold_q  <= '0;
                        if (lives_q != 2'd0) begin
                            lives_q <= lives_q - 2'd1;
                        end
                    end else begin
                        crash_q <= {w_left, w_right, w_up, w_hit};
                    end
                end
                S_MISS: begin
                    if (hold_q == c_HOLD_LAST) begin
                        if (lives_q != 2'd0) begin
                            serve_q <= 1'b1;
                            state_q <= S_PLAY;
                        end else begin
                            over_q  <= 1'b1;
                            state_q <= S_OVER;
                        end
                    end else begin
                        hold_q <= hold_q + c_HOLD_W'(1);
                    end
                end
                S_OVER: begin
                    over_q <= 1'b1;
                end
                default: begin
                    state_q <= S_PLAY;
                end
            endcase
        end
    end

`ifdef CRASH_SCORE_EN
    logic [7:0] score_q;

    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            score_q <= 8'd0;
        end else if (w_hit_new && (score_q != 8'hFF)) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign oScore = score_q;
`else
    assign oScore = 8'd0;
`endif

    assign oCrash     = crash_q;
    assign oServe     = serve_q;
    assign oLives     = lives_q;
    assign oGame_over = over_q;

endmodule
`default_nettype wire
